// File: rtl/msk_demux_buf_pkg.sv
// Shared constants for the masked routing gadgets.
package msk_demux_buf_pkg;
  localparam int DEFAULTSHARES = 2;
endpackage

// File: rtl/msk_buf_stage.sv
// One-entry valid/ready share register; data only moves on load, so each
// share bit stays in its own flop and no shares are ever combined.
module msk_buf_stage
  import msk_demux_buf_pkg::*;
#(
  parameter int d     = DEFAULTSHARES,
  parameter int count = 1
) (
  input  logic               clk,
  input  logic               syn_rst,
  input  logic               ld,
  input  logic [count*d-1:0] ld_data,
  output logic               ld_ok,
  output logic               valid,
  input  logic               ready,
  output logic [count*d-1:0] data
);
  logic               valid_q, valid_d;
  logic [count*d-1:0] data_q;

  // A load wins over a drain, so back-to-back transfers never bubble.
  always_comb valid_d = ld ? 1'b1 : (valid_q & ~ready);

  always_ff @(posedge clk) begin
    if (syn_rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      if (ld) data_q <= ld_data;
    end
  end

  assign ld_ok = ~valid_q | ready;
  assign valid = valid_q;
  assign data  = data_q;
endmodule

// File: rtl/msk_demux_buf.sv
// Masked 1-to-2 demux: a control select steers a sharing into one of two
// registered one-entry buffers. The top holds only steering logic.
module msk_demux_buf
  import msk_demux_buf_pkg::*;
#(
  parameter int d     = DEFAULTSHARES,
  parameter int count = 1
) (
  input  logic               clk,
  input  logic               syn_rst,
  input  logic               in_valid,
  output logic               in_ready,
  (* fv_type = "control" *)
  input  logic               sel,
  (* fv_type = "sharing", fv_latency = 1, fv_count = count *)
  input  logic [count*d-1:0] in_data,
  output logic               out_true_valid,
  input  logic               out_true_ready,
  (* fv_type = "sharing", fv_latency = 1, fv_count = count *)
  output logic [count*d-1:0] out_true_data,
  output logic               out_false_valid,
  input  logic               out_false_ready,
  (* fv_type = "sharing", fv_latency = 1, fv_count = count *)
  output logic [count*d-1:0] out_false_data
);
  logic ld_ok_t, ld_ok_f, acc, ld_t, ld_f;

  // Ready depends on the control select only, never on share values.
  assign in_ready = sel ? ld_ok_t : ld_ok_f;
  assign acc      = in_valid & in_ready;
  assign ld_t     = acc & sel;
  assign ld_f     = acc & ~sel;

  msk_buf_stage #(.d(d), .count(count)) u_true (
    .clk     (clk),
    .syn_rst (syn_rst),
    .ld      (ld_t),
    .ld_data (in_data),
    .ld_ok   (ld_ok_t),
    .valid   (out_true_valid),
    .ready   (out_true_ready),
    .data    (out_true_data)
  );

  msk_buf_stage #(.d(d), .count(count)) u_false (
    .clk     (clk),
    .syn_rst (syn_rst),
    .ld      (ld_f),
    .ld_data (in_data),
    .ld_ok   (ld_ok_f),
    .valid   (out_false_valid),
    .ready   (out_false_ready),
    .data    (out_false_data)
  );
endmodule
